// File: rtl/ram_banked_ctrl.sv
// Byte-lane banked data memory with sign/zero-extending loads and a two-beat
// path for word-spanning accesses. Upper address bits alias onto the array.
module ram_banked_ctrl #(
  parameter int ADDR_LENGTH = 10,
  parameter int WORDS       = 2 ** (ADDR_LENGTH - 2)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  o_dbg_state
);

  localparam int WW = ADDR_LENGTH - 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SPLIT = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready
  // (and rst is low); resp_valid is a one-cycle strobe with no backpressure.
  logic          w_accept;
  logic          w_illegal;
  logic [WW-1:0] w_word;
  logic [1:0]    w_off;
  logic [2:0]    w_n;
  logic          w_span;
  logic          w_unused_addr;

  logic [WW-1:0] r_word_nxt;
  logic [1:0]    r_off;
  logic [2:0]    r_n;
  logic          r_we;
  logic          r_unsigned;
  logic          r_err;
  logic          r_span;
  logic [31:0]   r_wdata;
  logic [31:0]   r_hold;

  logic [3:0]    w_lane_en;
  logic [3:0]    w_lane_we;
  logic [WW-1:0] w_lane_addr [4];
  logic [7:0]    w_lane_wd   [4];
  logic [31:0]   w_rd;
  logic [31:0]   w_src;
  logic [31:0]   w_gath;
  logic [31:0]   w_ext;

  assign req_ready     = (r_state != S_SPLIT);
  assign resp_valid    = (r_state == S_RESP);
  assign o_dbg_state   = r_state;
  assign w_accept      = req_valid && req_ready && !rst;
  assign w_illegal     = (req_size == 2'd3);
  assign w_word        = req_addr[ADDR_LENGTH-1:2];
  assign w_off         = req_addr[1:0];
  assign w_span        = ({1'b0, w_off} + w_n) > 3'd4;
  assign w_unused_addr = ^req_addr[31:ADDR_LENGTH];

  always_comb begin
    case (req_size)
      2'd0:    w_n = 3'd1;
      2'd1:    w_n = 3'd2;
      2'd2:    w_n = 3'd4;
      default: w_n = 3'd0;
    endcase
  end

  // Beat 1 (SPLIT) owns the lanes below the offset in word w+1; otherwise an
  // accepted request drives lanes off..off+n-1 of word w.
  always_comb begin
    for (int l = 0; l < 4; l++) begin
      w_lane_en[l]   = 1'b0;
      w_lane_we[l]   = 1'b0;
      w_lane_addr[l] = w_word;
      w_lane_wd[l]   = 8'h00;
      if (r_state == S_SPLIT) begin
        if (!rst && ((3'(l) + 3'd4) < ({1'b0, r_off} + r_n))) begin
          w_lane_en[l]   = 1'b1;
          w_lane_we[l]   = r_we;
          w_lane_addr[l] = r_word_nxt;
          w_lane_wd[l]   = r_wdata[{2'(l) - r_off, 3'b000} +: 8];
        end
      end else if (w_accept && !w_illegal && (2'(l) >= w_off) &&
                   ({1'b0, 2'(l) - w_off} < w_n)) begin
        w_lane_en[l]   = 1'b1;
        w_lane_we[l]   = req_we;
        w_lane_addr[l] = w_word;
        w_lane_wd[l]   = req_wdata[{2'(l) - w_off, 3'b000} +: 8];
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] r_mem [0:WORDS-1];
    logic [7:0] r_rd;
    always_ff @(posedge clk) begin
      if (w_lane_en[g]) begin
        if (w_lane_we[g]) r_mem[w_lane_addr[g]] <= w_lane_wd[g];
        else              r_rd <= r_mem[w_lane_addr[g]];
      end
    end
    assign w_rd[8*g +: 8] = r_rd;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_SPLIT: w_state_nxt = S_RESP;
      default: begin
        if (w_accept) w_state_nxt = (w_span && !w_illegal) ? S_SPLIT : S_RESP;
        else          w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_word_nxt <= w_word + 1'b1;
      r_off      <= w_off;
      r_n        <= w_n;
      r_we       <= req_we;
      r_unsigned <= req_unsigned;
      r_err      <= w_illegal;
      r_span     <= w_span && !w_illegal;
      r_wdata    <= req_wdata;
    end
    if (r_state == S_SPLIT) r_hold <= w_rd;
  end

  // After a split, lanes below the offset came from beat 1 (live read
  // register); the rest were parked in r_hold.
  always_comb begin
    for (int l = 0; l < 4; l++) begin
      if (r_span && (2'(l) >= r_off)) w_src[8*l +: 8] = r_hold[8*l +: 8];
      else                            w_src[8*l +: 8] = w_rd[8*l +: 8];
    end
    for (int k = 0; k < 4; k++) begin
      w_gath[8*k +: 8] = w_src[{2'(k) + r_off, 3'b000} +: 8];
    end
    case (r_n)
      3'd1:    w_ext = {{24{w_gath[7]  & ~r_unsigned}}, w_gath[7:0]};
      3'd2:    w_ext = {{16{w_gath[15] & ~r_unsigned}}, w_gath[15:0]};
      3'd4:    w_ext = w_gath;
      default: w_ext = 32'h0;
    endcase
  end

  assign resp_rdata = (resp_valid && !r_we && !r_err) ? w_ext : 32'h0;
  assign resp_err   = resp_valid && r_err;

endmodule

// File: tb/tb_ram_banked_ctrl.sv
// Directed bench for ram_banked_ctrl: aligned/misaligned stores and loads,
// extension, wrap/alias, back-to-back loads, illegal size, reset in SPLIT.
module tb_ram_banked_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  ram_banked_ctrl #(.ADDR_LENGTH(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .o_dbg_state  (o_dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT ready; returns at the negedge of the
  // response cycle so the next request can be issued immediately.
  task automatic access(input string tag, input bit we, input bit [1:0] size,
                        input bit uns, input bit [31:0] addr, input bit [31:0] wdata,
                        input int exp_lat, input bit [31:0] exp_rd, input bit exp_err);
    int          lat;
    bit          seen;
    logic [31:0] rd;
    logic        er;
    logic        rdy1;
    lat  = 0;
    seen = 1'b0;
    rd   = 32'h0;
    er   = 1'b0;
    rdy1 = 1'b1;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    check({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    while (!seen && lat < 4) begin
      @(negedge clk);
      lat++;
      if (lat == 1) rdy1 = req_ready;
      if (resp_valid) begin
        seen = 1'b1;
        rd   = resp_rdata;
        er   = resp_err;
      end
    end
    check({tag, "_latency"}, seen ? 32'(lat) : 32'h0, 32'(exp_lat));
    if (exp_lat == 2) check({tag, "_ready_split"}, {31'h0, rdy1}, 32'h0);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, {31'h0, er}, {31'h0, exp_err});
  endtask

  logic [31:0] b_addr [4];
  logic [31:0] b_exp  [4];

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_addr     = 32'h0;
    req_we       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_wdata    = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", {31'h0, resp_err}, 32'h0);
    check("rst_state", {30'h0, o_dbg_state}, 32'h0);
    rst = 1'b0;

    // Known background for words touched later.
    access("init_014", 1, 2, 0, 32'h014, 32'h0, 1, 32'h0, 0);
    access("init_020", 1, 2, 0, 32'h020, 32'h0, 1, 32'h0, 0);
    access("init_024", 1, 2, 0, 32'h024, 32'h0, 1, 32'h0, 0);
    access("init_000", 1, 2, 0, 32'h000, 32'h0, 1, 32'h0, 0);
    access("init_3fc", 1, 2, 0, 32'h3FC, 32'h0, 1, 32'h0, 0);

    access("sw_010",  1, 2, 0, 32'h010, 32'hDEADBEEF, 1, 32'h0, 0);
    access("lw_010",  0, 2, 0, 32'h010, 32'h0, 1, 32'hDEADBEEF, 0);
    access("lb_013",  0, 0, 0, 32'h013, 32'h0, 1, 32'hFFFFFFDE, 0);
    access("lbu_013", 0, 0, 1, 32'h013, 32'h0, 1, 32'h000000DE, 0);
    access("lh_012",  0, 1, 0, 32'h012, 32'h0, 1, 32'hFFFFDEAD, 0);
    access("lhu_010", 0, 1, 1, 32'h010, 32'h0, 1, 32'h0000BEEF, 0);

    access("sw_mis_013", 1, 2, 0, 32'h013, 32'h11223344, 2, 32'h0, 0);
    access("lw_010_b",   0, 2, 0, 32'h010, 32'h0, 1, 32'h44ADBEEF, 0);
    access("lw_014",     0, 2, 0, 32'h014, 32'h0, 1, 32'h00112233, 0);

    access("sh_wrap_3ff", 1, 1, 0, 32'h3FF, 32'h0000A5C3, 2, 32'h0, 0);
    access("lbu_3ff",     0, 0, 1, 32'h3FF, 32'h0, 1, 32'h000000C3, 0);
    access("lbu_000",     0, 0, 1, 32'h000, 32'h0, 1, 32'h000000A5, 0);
    access("lh_alias_7ff",0, 1, 0, 32'h7FF, 32'h0, 2, 32'hFFFFA5C3, 0);

    b_addr[0] = 32'h010; b_exp[0] = 32'h44ADBEEF;
    b_addr[1] = 32'h014; b_exp[1] = 32'h00112233;
    b_addr[2] = 32'h000; b_exp[2] = 32'h000000A5;
    b_addr[3] = 32'h3FC; b_exp[3] = 32'hC3000000;
    req_valid    = 1'b1;
    req_we       = 1'b0;
    req_size     = 2'd2;
    req_unsigned = 1'b0;
    req_addr     = b_addr[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 3) req_addr = b_addr[i+1];
      else       req_valid = 1'b0;
      @(negedge clk);
      check($sformatf("b2b_%0d_valid", i), {31'h0, resp_valid}, 32'h1);
      check($sformatf("b2b_%0d_rdata", i), resp_rdata, b_exp[i]);
    end

    access("illegal",     1, 3, 0, 32'h010, 32'hFFFFFFFF, 1, 32'h0, 1);
    access("lw_010_post", 0, 2, 0, 32'h010, 32'h0, 1, 32'h44ADBEEF, 0);

    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_size     = 2'd2;
    req_unsigned = 1'b0;
    req_addr     = 32'h022;
    req_wdata    = 32'hAABBCCDD;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    check("rsplit_ready_in_split", {31'h0, req_ready}, 32'h0);
    check("rsplit_valid_in_split", {31'h0, resp_valid}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rsplit_no_resp_%0d", i), {31'h0, resp_valid}, 32'h0);
      if (i == 0) check("rsplit_ready_after", {31'h0, req_ready}, 32'h1);
    end
    access("lw_020_after", 0, 2, 0, 32'h020, 32'h0, 1, 32'hCCDD0000, 0);
    access("lw_024_after", 0, 2, 0, 32'h024, 32'h0, 1, 32'h00000000, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
